// File: rtl/odd_even_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : odd_even_sort_engine
// Description : Iterative odd-even transposition sorter. One compare-exchange
//               slice of NUM_ELEM/2 comparators is applied per clock. Even
//               phases exchange pairs (0,1),(2,3),... and odd phases exchange
//               pairs (1,2),(3,4),... A start/done handshake frames each sort.
//               Optional feature macro: SORT_EARLY_EXIT_EN. When it is
//               defined, the sort stops after two consecutive phases that
//               perform no swap.
// Ports       : i_clk       - clock, rising edge
//               i_rst_n     - asynchronous reset, active low
//               i_start     - load i_data and begin a sort (IDLE or DONE only)
//               i_mode      - 0 ascending, 1 descending (sampled with i_start)
//               i_data      - element k at [k*SIZE_DATA +: SIZE_DATA]
//               o_busy      - high while sorting
//               o_done      - one-cycle pulse, o_data holds the sorted result
//               o_data      - working/result array, same packing as i_data
//               o_phase_cnt - phases executed in the current/last sort
// Revision    : 1.0 - initial release
// ============================================================================
module odd_even_sort_engine #(
  parameter int SIZE_DATA = 8,
  parameter int NUM_ELEM  = 8,
  parameter int CNT_W     = $clog2(NUM_ELEM + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_mode,
  input  logic [NUM_ELEM*SIZE_DATA-1:0] i_data,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [NUM_ELEM*SIZE_DATA-1:0] o_data,
  output logic [CNT_W-1:0]              o_phase_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SIZE_DATA-1:0] r_arr     [NUM_ELEM];
  logic [SIZE_DATA-1:0] w_arr_nxt [NUM_ELEM];
  logic                 r_mode;
  logic [CNT_W-1:0]     r_phase_cnt;

  logic [NUM_ELEM-2:0]  w_swap;
  logic                 w_odd_phase;
  logic                 w_load;
  logic                 w_last_phase;
  logic                 w_early_exit;

  assign w_odd_phase  = r_phase_cnt[0];
  assign w_load       = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_phase = (r_phase_cnt == CNT_W'(NUM_ELEM - 1));

  // One comparator per adjacent position; only those whose left index parity
  // matches the phase parity are enabled, so active pairs never overlap.
  generate
    for (genvar i = 0; i < NUM_ELEM - 1; i++) begin : g_cmp
      localparam logic C_ODD = 1'(i % 2);
      assign w_swap[i] = (w_odd_phase == C_ODD) &&
                         (r_mode ? (r_arr[i] < r_arr[i+1])
                                 : (r_arr[i] > r_arr[i+1]));
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < NUM_ELEM; k++) begin
      w_arr_nxt[k] = r_arr[k];
    end
    for (int k = 0; k < NUM_ELEM - 1; k++) begin
      if (w_swap[k]) begin
        w_arr_nxt[k]   = r_arr[k+1];
        w_arr_nxt[k+1] = r_arr[k];
      end
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  // A clean phase following a clean phase means both parities are already
  // in order, so the whole array is sorted.
  logic r_prev_clean;
  logic w_swap_any;

  assign w_swap_any   = |w_swap;
  assign w_early_exit = (r_phase_cnt != '0) && r_prev_clean && !w_swap_any;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_clean <= 1'b0;
    end else if (w_load) begin
      r_prev_clean <= 1'b0;
    end else if (r_state == ST_SORT) begin
      r_prev_clean <= !w_swap_any;
    end
  end
`else
  assign w_early_exit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_SORT;
        end
      end
      ST_SORT: begin
        if (w_last_phase || w_early_exit) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_SORT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Working array, latched mode and phase counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        r_arr[k] <= '0;
      end
      r_mode      <= 1'b0;
      r_phase_cnt <= '0;
    end else if (w_load) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        r_arr[k] <= i_data[k*SIZE_DATA +: SIZE_DATA];
      end
      r_mode      <= i_mode;
      r_phase_cnt <= '0;
    end else if (r_state == ST_SORT) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        r_arr[k] <= w_arr_nxt[k];
      end
      r_phase_cnt <= r_phase_cnt + CNT_W'(1);
    end
  end

  generate
    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_pack
      assign o_data[k*SIZE_DATA +: SIZE_DATA] = r_arr[k];
    end
  endgenerate

  assign o_busy      = (r_state == ST_SORT);
  assign o_done      = (r_state == ST_DONE);
  assign o_phase_cnt = r_phase_cnt;

endmodule
`default_nettype wire

// File: tb/tb_odd_even_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_odd_even_sort_engine
// Description : Scoreboard bench for odd_even_sort_engine (NUM_ELEM=8,
//               SIZE_DATA=8). Stimulus pushes expected results; a monitor
//               checks each o_done pulse against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_odd_even_sort_engine;

  localparam int SIZE_DATA = 8;
  localparam int NUM_ELEM  = 8;
  localparam int CNT_W     = $clog2(NUM_ELEM + 1);
  localparam int W         = SIZE_DATA * NUM_ELEM;

`ifdef SORT_EARLY_EXIT_EN
  localparam int FULL_PH   = -1;   // data dependent, range checked
  localparam int SORTED_PH = 2;
`else
  localparam int FULL_PH   = 8;
  localparam int SORTED_PH = 8;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [W-1:0]     din;
  logic             busy;
  logic             done;
  logic [W-1:0]     dout;
  logic [CNT_W-1:0] phase_cnt;

  odd_even_sort_engine #(
    .SIZE_DATA(SIZE_DATA),
    .NUM_ELEM (NUM_ELEM)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_mode     (mode),
    .i_data     (din),
    .o_busy     (busy),
    .o_done     (done),
    .o_data     (dout),
    .o_phase_cnt(phase_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] data;
    int           phases;
    int           start_cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [W-1:0] sort_ref(input logic [W-1:0] d, input logic m);
    logic [7:0] a [8];
    logic [7:0] t;
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) a[i] = d[i*8 +: 8];
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 7 - i; j++) begin
        if (m ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  // Monitor: every done pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending sort");
        end else begin
          e = q.pop_front();
          chk("result_data", dout, e.data);
          if (e.phases >= 0) begin
            chk("phase_cnt", W'(phase_cnt), W'(e.phases));
            chk("latency", W'(cyc - e.start_cyc), W'(e.phases));
            chk("busy_cycles", W'(busy_cnt), W'(e.phases));
          end else begin
            n_checks++;
            if (phase_cnt < 2 || phase_cnt > 8) begin
              n_errors++;
              $display("FAIL phase_range: got %0d expected 2..8", phase_cnt);
            end
            chk("latency_vs_busy", W'(cyc - e.start_cyc), W'(busy_cnt));
          end
        end
        busy_cnt = 0;
      end
    end
  end

  // Caller sits just after a negedge; the start is sampled on the next edge.
  task automatic start_sort(input logic m, input logic [W-1:0] d, input logic [W-1:0] exp,
                            input int ph, input bit push);
    exp_t e;
    start = 1'b1;
    mode  = m;
    din   = d;
    if (push) begin
      e.data      = exp;
      e.phases    = ph;
      e.start_cyc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  initial begin
    logic [W-1:0] r;
    logic         m;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  W'(busy), '0);
    chk("rst_done",  W'(done), '0);
    chk("rst_data",  dout, '0);
    chk("rst_phase", W'(phase_cnt), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reverse order, ascending
    start_sort(1'b0, pack8(7,6,5,4,3,2,1,0), pack8(0,1,2,3,4,5,6,7), FULL_PH, 1'b1);
    wait_done("t1");
    @(negedge clk);
    chk("t1_done_pulse", W'(done), '0);
    chk("t1_hold_data", dout, pack8(0,1,2,3,4,5,6,7));

    // Descending with duplicates and extreme values
    start_sort(1'b1, pack8(3,9,3,0,255,1,9,3), pack8(255,9,9,3,3,3,1,0), FULL_PH, 1'b1);
    wait_done("t2");
    @(negedge clk);

    // Already sorted input
    start_sort(1'b0, pack8(0,1,2,3,4,5,6,7), pack8(0,1,2,3,4,5,6,7), SORTED_PH, 1'b1);
    wait_done("t3");
    @(negedge clk);
    chk("t3_hold_phase", W'(phase_cnt), W'(SORTED_PH));

    // Start during SORT ignored; start held in DONE chains a new sort
    start_sort(1'b0, pack8(5,3,8,1,9,2,7,4), pack8(1,2,3,4,5,7,8,9), FULL_PH, 1'b1);
    repeat (2) @(negedge clk);
    start_sort(1'b1, pack8(200,100,50,25,12,6,3,1), '0, 0, 1'b0);
    wait_done("t4a");
    start_sort(1'b1, pack8(10,20,30,40,50,60,70,80), pack8(80,70,60,50,40,30,20,10), FULL_PH, 1'b1);
    chk("t4_chain_busy", W'(busy), W'(1));
    wait_done("t4b");
    @(negedge clk);

    // Reset mid-sort aborts without a done pulse
    start_sort(1'b0, pack8(9,8,7,6,5,4,3,2), '0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  W'(busy), '0);
    chk("abort_data",  dout, '0);
    chk("abort_phase", W'(phase_cnt), '0);
    chk("abort_done",  W'(done), '0);
    @(negedge clk);
    rst_n    = 1'b1;
    busy_cnt = 0;
    repeat (12) @(negedge clk);
    start_sort(1'b0, pack8(4,4,1,200,0,7,7,2), pack8(0,1,2,4,4,7,7,200), FULL_PH, 1'b1);
    wait_done("t5");
    @(negedge clk);

    // Random vectors against the reference sort
    for (int n = 0; n < 60; n++) begin
      r = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      start_sort(m, r, sort_ref(r, m), FULL_PH, 1'b1);
      wait_done("rand");
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", W'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
